dual_input_deserializer: RTL and testbench

//   Downstream stage of the dual-input D flip-flop. Consumes its registered serial

---
 rtl/dual_input_deserializer_if.sv | 27 ++
 rtl/dual_input_deserializer.sv | 145 ++++++++++++++
 tb/tb_dual_input_deserializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dual_input_deserializer_if.sv
// Handshake bundle between the upstream serial producer/word consumer and the deserializer.
interface dual_input_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             bit_src;
    logic [WIDTH-1:0] word_out;
    logic             word_src;
    logic             word_valid;
    logic             word_ready;
    logic [CNT_W-1:0] bit_count;
    logic             src_err;
    logic             overflow;

    modport master (
        output bit_in, bit_valid, bit_src, word_ready,
        input  word_out, word_src, word_valid, bit_count, src_err, overflow
    );

    modport slave (
        input  bit_in, bit_valid, bit_src, word_ready,
        output word_out, word_src, word_valid, bit_count, src_err, overflow
    );
endinterface

// File: rtl/dual_input_deserializer.sv
// Packs the serial Q stream of the dual-input flip-flop into source-tagged words
// on a valid/ready handshake; a source change mid-word aborts and restarts the word.
module dual_input_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    dual_input_deserializer_if.slave io
);
    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] word_r, word_s;
    logic             src_r, src_s;
    logic             valid_r, valid_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             src_err_r, src_err_s;
    logic             overflow_r, overflow_s;

    // k is the arrival index of the bit; positions not yet written stay 0
    function automatic logic [WIDTH-1:0] place_bit(
        input logic [WIDTH-1:0] base,
        input logic [CNT_W-1:0] k,
        input logic             b
    );
        logic [CNT_W-1:0] shamt_s;
        logic [WIDTH-1:0] mask_s;
        if (MSB_FIRST) begin
            shamt_s = TOP_IDX - k;
        end else begin
            shamt_s = k;
        end
        mask_s = ONE_W << shamt_s;
        return b ? (base | mask_s) : base;
    endfunction

    // Output and state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            word_r     <= {WIDTH{1'b0}};
            src_r      <= 1'b0;
            valid_r    <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            src_err_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_r     <= word_s;
            src_r      <= src_s;
            valid_r    <= valid_s;
            count_r    <= count_s;
            src_err_r  <= src_err_s;
            overflow_r <= overflow_s;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_s    = state_r;
        word_s     = word_r;
        src_s      = src_r;
        valid_s    = valid_r;
        count_s    = count_r;
        src_err_s  = 1'b0;
        overflow_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (io.bit_valid) begin
                    word_s  = place_bit({WIDTH{1'b0}}, {CNT_W{1'b0}}, io.bit_in);
                    src_s   = io.bit_src;
                    count_s = CNT_ONE;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (!io.bit_valid) begin
                    state_s = SHIFT;
                end else if (io.bit_src == src_r) begin
                    word_s  = place_bit(word_r, count_r, io.bit_in);
                    count_s = count_r + CNT_ONE;
                    if (count_r == TOP_IDX) begin
                        valid_s = 1'b1;
                        state_s = FULL;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    // Offending bit is kept as the first bit of a fresh word
                    src_err_s = 1'b1;
                    word_s    = place_bit({WIDTH{1'b0}}, {CNT_W{1'b0}}, io.bit_in);
                    src_s     = io.bit_src;
                    count_s   = CNT_ONE;
                    state_s   = SHIFT;
                end
            end
            FULL: begin
                if (io.word_ready) begin
                    valid_s = 1'b0;
                    if (io.bit_valid) begin
                        word_s  = place_bit({WIDTH{1'b0}}, {CNT_W{1'b0}}, io.bit_in);
                        src_s   = io.bit_src;
                        count_s = CNT_ONE;
                        state_s = SHIFT;
                    end else begin
                        word_s  = {WIDTH{1'b0}};
                        count_s = {CNT_W{1'b0}};
                        state_s = IDLE;
                    end
                end else if (io.bit_valid) begin
                    overflow_s = 1'b1;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = IDLE;
                word_s  = {WIDTH{1'b0}};
                src_s   = 1'b0;
                valid_s = 1'b0;
                count_s = {CNT_W{1'b0}};
            end
        endcase
    end

    assign io.word_out   = word_r;
    assign io.word_src   = src_r;
    assign io.word_valid = valid_r;
    assign io.bit_count  = count_r;
    assign io.src_err    = src_err_r;
    assign io.overflow   = overflow_r;
endmodule

// File: tb/tb_dual_input_deserializer.sv
// Directed bench: an MSB-first and an LSB-first instance fed the same stream,
// checked against a hand-computed vector table plus a back-to-back word sequence.
module tb_dual_input_deserializer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dual_input_deserializer_if #(.WIDTH(W)) bus_m ();
    dual_input_deserializer_if #(.WIDTH(W)) bus_l ();

    dual_input_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .io(bus_m));
    dual_input_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .io(bus_l));

    typedef struct {
        logic          rst, v, b, s, rdy, cw;
        logic [7:0]    em, el;
        logic          es, ev;
        logic [CW-1:0] ec;
        logic          ee, eo;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, v, b, s, rdy, cw, input logic [7:0] em, el,
                                input logic es, ev, input int ec, input logic ee, eo);
        vec_t r;
        r.rst = rst; r.v = v; r.b = b; r.s = s; r.rdy = rdy; r.cw = cw;
        r.em = em; r.el = el; r.es = es; r.ev = ev; r.ec = CW'(ec); r.ee = ee; r.eo = eo;
        tbl.push_back(r);
    endfunction

    task automatic drive(input logic rst, v, b, s, rdy);
        reset = rst;
        bus_m.bit_valid = v;  bus_l.bit_valid = v;
        bus_m.bit_in    = b;  bus_l.bit_in    = b;
        bus_m.bit_src   = s;  bus_l.bit_src   = s;
        bus_m.word_ready = rdy; bus_l.word_ready = rdy;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7-i];
        return y;
    endfunction

    logic [7:0] pats [2];
    int         words_seen;

    initial begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        //   rst v  b  s  rdy cw  msb    lsb    es ev cnt err ovf
        // reset with busy inputs
        add(1, 1, 1, 1, 1,  1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0,  1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // word 1,0,1,1,0,0,1,0 from D1
        add(0, 1, 1, 0, 1,  1, 8'h80, 8'h01, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1,  1, 8'h80, 8'h01, 0, 0, 2, 0, 0);
        add(0, 1, 1, 0, 1,  1, 8'hA0, 8'h05, 0, 0, 3, 0, 0);
        add(0, 1, 1, 0, 1,  1, 8'hB0, 8'h0D, 0, 0, 4, 0, 0);
        add(0, 1, 0, 0, 1,  1, 8'hB0, 8'h0D, 0, 0, 5, 0, 0);
        add(0, 1, 0, 0, 1,  1, 8'hB0, 8'h0D, 0, 0, 6, 0, 0);
        add(0, 1, 1, 0, 1,  1, 8'hB2, 8'h4D, 0, 0, 7, 0, 0);
        add(0, 1, 0, 0, 1,  1, 8'hB2, 8'h4D, 0, 1, 8, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // source change on the 4th bit
        add(0, 1, 1, 0, 0,  1, 8'h80, 8'h01, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0,  1, 8'hC0, 8'h03, 0, 0, 2, 0, 0);
        add(0, 1, 0, 0, 0,  1, 8'hC0, 8'h03, 0, 0, 3, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h80, 8'h01, 1, 0, 1, 1, 0);
        add(0, 1, 0, 1, 0,  1, 8'h80, 8'h01, 1, 0, 2, 0, 0);
        add(0, 1, 0, 1, 0,  1, 8'h80, 8'h01, 1, 0, 3, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h90, 8'h09, 1, 0, 4, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h98, 8'h19, 1, 0, 5, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h9C, 8'h39, 1, 0, 6, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h9E, 8'h79, 1, 0, 7, 0, 0);
        add(0, 1, 0, 1, 0,  1, 8'h9E, 8'h79, 1, 1, 8, 0, 0);
        // full and stalled: two dropped bits, then transfer with a new first bit
        add(0, 1, 1, 0, 0,  1, 8'h9E, 8'h79, 1, 1, 8, 0, 1);
        add(0, 1, 0, 1, 0,  1, 8'h9E, 8'h79, 1, 1, 8, 0, 1);
        add(0, 0, 0, 0, 0,  1, 8'h9E, 8'h79, 1, 1, 8, 0, 0);
        add(0, 1, 1, 0, 1,  1, 8'h80, 8'h01, 0, 0, 1, 0, 0);
        // reset mid-word at bit_count=5
        add(0, 1, 0, 0, 0,  1, 8'h80, 8'h01, 0, 0, 2, 0, 0);
        add(0, 1, 1, 0, 0,  1, 8'hA0, 8'h05, 0, 0, 3, 0, 0);
        add(0, 1, 1, 0, 0,  1, 8'hB0, 8'h0D, 0, 0, 4, 0, 0);
        add(0, 1, 0, 0, 0,  1, 8'hB0, 8'h0D, 0, 0, 5, 0, 0);
        add(1, 1, 1, 1, 1,  1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        // fresh word 0,1,1,0,(gap),1,0,0,1 from D2
        add(0, 1, 0, 1, 0,  1, 8'h00, 8'h00, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h40, 8'h02, 1, 0, 2, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h60, 8'h06, 1, 0, 3, 0, 0);
        add(0, 1, 0, 1, 0,  1, 8'h60, 8'h06, 1, 0, 4, 0, 0);
        add(0, 0, 1, 0, 0,  1, 8'h60, 8'h06, 1, 0, 4, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h68, 8'h16, 1, 0, 5, 0, 0);
        add(0, 1, 0, 1, 0,  1, 8'h68, 8'h16, 1, 0, 6, 0, 0);
        add(0, 1, 0, 1, 0,  1, 8'h68, 8'h16, 1, 0, 7, 0, 0);
        add(0, 1, 1, 1, 0,  1, 8'h69, 8'h96, 1, 1, 8, 0, 0);
        add(0, 0, 0, 0, 0,  1, 8'h69, 8'h96, 1, 1, 8, 0, 0);
        add(0, 0, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].s, tbl[i].rdy);
            @(posedge clk);
            #1;
            if (tbl[i].cw) begin
                chk($sformatf("row%0d word_msb", i), 32'(bus_m.word_out), 32'(tbl[i].em));
                chk($sformatf("row%0d word_lsb", i), 32'(bus_l.word_out), 32'(tbl[i].el));
                chk($sformatf("row%0d word_src", i), 32'(bus_m.word_src), 32'(tbl[i].es));
            end
            chk($sformatf("row%0d word_valid", i), 32'(bus_m.word_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d word_valid_lsb", i), 32'(bus_l.word_valid), 32'(tbl[i].ev));
            chk($sformatf("row%0d bit_count", i), 32'(bus_m.bit_count), 32'(tbl[i].ec));
            chk($sformatf("row%0d src_err", i), 32'(bus_m.src_err), 32'(tbl[i].ee));
            chk($sformatf("row%0d overflow", i), 32'(bus_m.overflow), 32'(tbl[i].eo));
        end

        // Back-to-back words with word_ready held high: no bubble between them
        pats[0] = 8'hC5;
        pats[1] = 8'h3A;
        words_seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, pats[c/8][7 - (c % 8)], 1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("b2b cyc%0d word_valid", c), 32'(bus_m.word_valid), 32'((c % 8) == 7));
            chk($sformatf("b2b cyc%0d bit_count", c), 32'(bus_m.bit_count), 32'((c % 8) + 1));
            if (bus_m.word_valid) begin
                chk($sformatf("b2b word%0d msb", words_seen), 32'(bus_m.word_out), 32'(pats[c/8]));
                chk($sformatf("b2b word%0d lsb", words_seen), 32'(bus_l.word_out), 32'(rev8(pats[c/8])));
                words_seen++;
            end
        end
        chk("b2b word count", 32'(words_seen), 32'd2);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b drain word_valid", 32'(bus_m.word_valid), 32'd0);
        chk("b2b drain bit_count", 32'(bus_m.bit_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
